// File: rtl/mtsp_sf_wb_queue_if.sv
// SF writeback queue bus: SF result strobe/data in, two per-phase register-file
// write ports out, plus stall and sticky error flags.
interface mtsp_sf_wb_queue_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        SF_PHASE_EN;
  logic [DATA_W-1:0] SF_DOUT;
  logic              WB0_VALID;
  logic              WB0_READY;
  logic [DATA_W-1:0] WB0_DATA;
  logic              WB1_VALID;
  logic              WB1_READY;
  logic [DATA_W-1:0] WB1_DATA;
  logic [1:0]        STALL;
  logic [1:0]        OVERFLOW;
  logic              DUAL_ERR;

  modport master (
    output SF_PHASE_EN, SF_DOUT, WB0_READY, WB1_READY,
    input  WB0_VALID, WB0_DATA, WB1_VALID, WB1_DATA, STALL, OVERFLOW, DUAL_ERR
  );

  modport slave (
    input  SF_PHASE_EN, SF_DOUT, WB0_READY, WB1_READY,
    output WB0_VALID, WB0_DATA, WB1_VALID, WB1_DATA, STALL, OVERFLOW, DUAL_ERR
  );
endinterface

// File: rtl/mtsp_sf_wb_queue.sv
// Per-phase writeback FIFOs for SF EXP results with early issue stall.
// Optional MTSP_SF_WB_BYPASS_EN: empty-queue results reach the write port in the same cycle.
module mtsp_sf_wb_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int PIPE_SLACK = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  mtsp_sf_wb_queue_if.slave    bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - PIPE_SLACK + 1);

  logic [1:0]        ready;
  logic [1:0]        valid;
  logic [1:0]        stall;
  logic [1:0]        overflow;
  logic [DATA_W-1:0] data [2];
  logic              dual_err;

  assign ready = {bus.WB1_READY, bus.WB0_READY};

  for (genvar g = 0; g < 2; g++) begin : g_phase
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic              q_valid;
    logic              full;
    logic              pop;
    logic              push;
    logic              bypass_take;
    logic              ovf;

    assign q_valid = (count != '0);
    assign full    = (count == DEPTH_C);
    assign pop     = q_valid & ready[g];

`ifdef MTSP_SF_WB_BYPASS_EN
    // Empty queue: the incoming word is presented directly and, if accepted, never stored.
    assign bypass_take = ~q_valid & bus.SF_PHASE_EN[g] & ready[g];
    assign valid[g]    = q_valid | bus.SF_PHASE_EN[g];
    assign data[g]     = q_valid ? mem[head] :
                         (bus.SF_PHASE_EN[g] ? bus.SF_DOUT : '0);
`else
    assign bypass_take = 1'b0;
    assign valid[g]    = q_valid;
    assign data[g]     = q_valid ? mem[head] : '0;
`endif

    // A full queue still takes a word when its head leaves in the same cycle.
    assign push = bus.SF_PHASE_EN[g] & (~full | pop) & ~bypass_take;

    always_ff @(posedge CLK) begin
      if (push) mem[tail] <= bus.SF_DOUT;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (bus.SF_PHASE_EN[g] & full & ~pop) ovf <= 1'b1;
      end
    end

    assign stall[g]    = (count >= STALL_TH);
    assign overflow[g] = ovf;
  end

  always_ff @(posedge CLK) begin
    if (RST)                          dual_err <= 1'b0;
    else if (&bus.SF_PHASE_EN)        dual_err <= 1'b1;
  end

  assign bus.WB0_VALID = valid[0];
  assign bus.WB0_DATA  = data[0];
  assign bus.WB1_VALID = valid[1];
  assign bus.WB1_DATA  = data[1];
  assign bus.STALL     = stall;
  assign bus.OVERFLOW  = overflow;
  assign bus.DUAL_ERR  = dual_err;
endmodule

// File: tb/tb_mtsp_sf_wb_queue.sv
// Scoreboard bench for mtsp_sf_wb_queue: stimulus queues expected words per phase,
// a negedge monitor pops and compares on every accepted write.
module tb_mtsp_sf_wb_queue;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] sb0[$];
  logic [31:0] sb1[$];
  logic [1:0]  ovf_exp;

  mtsp_sf_wb_queue_if #(.DATA_W(32)) bus ();

  mtsp_sf_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .PIPE_SLACK(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest expected word of that phase.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.WB0_VALID && bus.WB0_READY) begin
        total++;
        if (sb0.size() == 0) begin
          bad++;
          $display("FAIL wb0_unexpected: got %h expected nothing at %0t", bus.WB0_DATA, $time);
        end else begin
          logic [31:0] e0;
          e0 = sb0.pop_front();
          if (bus.WB0_DATA !== e0) begin
            bad++;
            $display("FAIL wb0_data: got %h expected %h at %0t", bus.WB0_DATA, e0, $time);
          end
        end
      end
      if (bus.WB1_VALID && bus.WB1_READY) begin
        total++;
        if (sb1.size() == 0) begin
          bad++;
          $display("FAIL wb1_unexpected: got %h expected nothing at %0t", bus.WB1_DATA, $time);
        end else begin
          logic [31:0] e1;
          e1 = sb1.pop_front();
          if (bus.WB1_DATA !== e1) begin
            bad++;
            $display("FAIL wb1_data: got %h expected %h at %0t", bus.WB1_DATA, e1, $time);
          end
        end
      end
    end
  end

  // One cycle of stimulus; the expected queues follow the full/drop rules.
  task automatic step(input logic [1:0] en, input logic [31:0] d, input logic r0, input logic r1);
    @(posedge CLK);
    #1;
    bus.SF_PHASE_EN = en;
    bus.SF_DOUT     = d;
    bus.WB0_READY   = r0;
    bus.WB1_READY   = r1;
    if (en[0]) begin
      if (sb0.size() < DEPTH || r0) sb0.push_back(d);
      else ovf_exp[0] = 1'b1;
    end
    if (en[1]) begin
      if (sb1.size() < DEPTH || r1) sb1.push_back(d);
      else ovf_exp[1] = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.SF_PHASE_EN = 2'b00;
    bus.SF_DOUT     = '0;
    bus.WB0_READY   = 1'b0;
    bus.WB1_READY   = 1'b0;
    sb0.delete();
    sb1.delete();
    ovf_exp = 2'b00;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v0"},   {31'd0, bus.WB0_VALID}, 32'd0);
    chk({tag, "_v1"},   {31'd0, bus.WB1_VALID}, 32'd0);
    chk({tag, "_d0"},   bus.WB0_DATA, 32'd0);
    chk({tag, "_d1"},   bus.WB1_DATA, 32'd0);
    chk({tag, "_stall"}, {30'd0, bus.STALL}, 32'd0);
  endtask

  initial begin
    bus.SF_PHASE_EN = 2'b00;
    bus.SF_DOUT     = '0;
    bus.WB0_READY   = 1'b0;
    bus.WB1_READY   = 1'b0;
    ovf_exp         = 2'b00;

    do_reset();
    chk_idle("reset");
    chk("reset_ovf",  {30'd0, bus.OVERFLOW}, 32'd0);
    chk("reset_dual", {31'd0, bus.DUAL_ERR}, 32'd0);

    // Single push on phase 0, held in the queue.
    step(2'b01, 32'h00BF8000, 1'b0, 1'b0);
    step(2'b00, 32'h0, 1'b0, 1'b0);
    chk("first_v0", {31'd0, bus.WB0_VALID}, 32'd1);
    chk("first_d0", bus.WB0_DATA, 32'h00BF8000);
    chk("first_v1", {31'd0, bus.WB1_VALID}, 32'd0);
    do_reset();
    chk_idle("midrst");

    // Fill phase 0, watch stall, drop the fifth word.
    step(2'b01, 32'd1, 1'b0, 1'b0);
    step(2'b01, 32'd2, 1'b0, 1'b0);
    chk("stall_cnt1", {30'd0, bus.STALL}, 32'd0);
    step(2'b01, 32'd3, 1'b0, 1'b0);
    chk("stall_cnt2", {30'd0, bus.STALL}, 32'd1);
    step(2'b01, 32'd4, 1'b0, 1'b0);
    step(2'b01, 32'd5, 1'b0, 1'b0);
    chk("ovf_before", {30'd0, bus.OVERFLOW}, 32'd0);
    step(2'b00, 32'd0, 1'b0, 1'b0);
    chk("ovf_set",  {30'd0, bus.OVERFLOW}, {30'd0, ovf_exp});
    chk("ovf_p0",   {30'd0, bus.OVERFLOW}, 32'd1);
    chk("full_head", bus.WB0_DATA, 32'd1);
    for (int i = 0; i < 4; i++) step(2'b00, 32'd0, 1'b1, 1'b0);
    step(2'b00, 32'd0, 1'b0, 1'b0);
    chk("drain_empty_v0", {31'd0, bus.WB0_VALID}, 32'd0);
    chk("drain_sb0", sb0.size(), 32'd0);
    chk("ovf_sticky", {30'd0, bus.OVERFLOW}, 32'd1);

    // Full phase 1 with simultaneous pop and push.
    do_reset();
    step(2'b10, 32'h11, 1'b0, 1'b0);
    step(2'b10, 32'h12, 1'b0, 1'b0);
    step(2'b10, 32'h13, 1'b0, 1'b0);
    step(2'b10, 32'h14, 1'b0, 1'b0);
    step(2'b10, 32'hAA, 1'b0, 1'b1);
    step(2'b00, 32'h0, 1'b0, 1'b0);
    chk("pp_head",  bus.WB1_DATA, 32'h12);
    chk("pp_stall", {30'd0, bus.STALL}, 32'd2);
    chk("pp_ovf",   {30'd0, bus.OVERFLOW}, 32'd0);
    for (int i = 0; i < 4; i++) step(2'b00, 32'd0, 1'b0, 1'b1);
    step(2'b00, 32'd0, 1'b0, 1'b0);
    chk("pp_sb1", sb1.size(), 32'd0);
    chk("pp_v1",  {31'd0, bus.WB1_VALID}, 32'd0);

    // Alternating phases with both ports ready.
    for (int k = 0; k < 8; k++)
      step((k % 2 == 0) ? 2'b01 : 2'b10, 32'h100 + k, 1'b1, 1'b1);
    step(2'b00, 32'd0, 1'b1, 1'b1);
    step(2'b00, 32'd0, 1'b0, 1'b0);
    chk("alt_sb0", sb0.size(), 32'd0);
    chk("alt_sb1", sb1.size(), 32'd0);

    // Illegal dual strobe.
    step(2'b11, 32'h55, 1'b0, 1'b0);
    step(2'b00, 32'h0, 1'b0, 1'b0);
    chk("dual_d0",  bus.WB0_DATA, 32'h55);
    chk("dual_d1",  bus.WB1_DATA, 32'h55);
    chk("dual_err", {31'd0, bus.DUAL_ERR}, 32'd1);
    step(2'b00, 32'h0, 1'b1, 1'b1);
    step(2'b00, 32'h0, 1'b0, 1'b0);
    chk("dual_sticky", {31'd0, bus.DUAL_ERR}, 32'd1);
    chk("dual_sb0", sb0.size(), 32'd0);
    do_reset();
    chk("dual_clr", {31'd0, bus.DUAL_ERR}, 32'd0);

    // Empty-queue latency.
    step(2'b01, 32'h77, 1'b1, 1'b0);
`ifdef MTSP_SF_WB_BYPASS_EN
    chk("byp_v0_same", {31'd0, bus.WB0_VALID}, 32'd1);
    chk("byp_d0_same", bus.WB0_DATA, 32'h77);
    step(2'b00, 32'h0, 1'b0, 1'b0);
    chk("byp_v0_next", {31'd0, bus.WB0_VALID}, 32'd0);
`else
    chk("lat_v0_same", {31'd0, bus.WB0_VALID}, 32'd0);
    step(2'b00, 32'h0, 1'b0, 1'b0);
    chk("lat_v0_next", {31'd0, bus.WB0_VALID}, 32'd1);
    chk("lat_d0_next", bus.WB0_DATA, 32'h77);
`endif
    step(2'b00, 32'h0, 1'b1, 1'b0);
    step(2'b00, 32'h0, 1'b0, 1'b0);
    chk("lat_sb0", sb0.size(), 32'd0);
    chk("lat_v0_end", {31'd0, bus.WB0_VALID}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
